// File: rtl/fp_adder_pkg.sv
// rtl/fp_adder_pkg.sv - shared state type, stage indices and strobe helper for the FP adder sequencer
package fp_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  localparam int STG_ALIGN = 0;
  localparam int STG_ADD   = 1;
  localparam int STG_NORM  = 2;
  localparam int STG_PACK  = 3;

  localparam int STAGE_W = STG_PACK + 1;
  localparam int Q_W     = 2;

  // One-hot strobe for a stage index; bit order follows the STG_* constants.
  function automatic logic [STAGE_W-1:0] stage_strobe(input logic [Q_W-1:0] idx);
    stage_strobe = STAGE_W'(1) << idx;
  endfunction

endpackage

// File: rtl/fp_stage_sequencer_if.sv
// rtl/fp_stage_sequencer_if.sv - control/status bundle of the stage sequencer (abort only with FP_SEQ_ABORT_EN)
interface fp_stage_sequencer_if;
  import fp_adder_pkg::*;

  logic               clk_en;
  logic               start;
`ifdef FP_SEQ_ABORT_EN
  logic               abort;
`endif
  logic [STAGE_W-1:0] stage;
  logic [Q_W-1:0]     q;
  logic               busy;
  logic               done;

  modport master (
    output clk_en,
    output start,
`ifdef FP_SEQ_ABORT_EN
    output abort,
`endif
    input  stage,
    input  q,
    input  busy,
    input  done
  );

  modport slave (
    input  clk_en,
    input  start,
`ifdef FP_SEQ_ABORT_EN
    input  abort,
`endif
    output stage,
    output q,
    output busy,
    output done
  );

endinterface

// File: rtl/step_down_counter.sv
// rtl/step_down_counter.sv - loadable down-counter that saturates at zero
module step_down_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic [W-1:0] q,
  output logic         zero
);

  // Load wins over decrement; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_value;
    end else if (enable && (q != '0)) begin
      q <= q - W'(1);
    end
  end

  assign zero = (q == '0);

endmodule

// File: rtl/fp_stage_sequencer.sv
// rtl/fp_stage_sequencer.sv - IDLE/RUN/DONE sequencer strobing align/add/normalize/pack; optional abort via FP_SEQ_ABORT_EN
module fp_stage_sequencer
  import fp_adder_pkg::*;
#(
  parameter int NUM_STAGES = 4
) (
  input  logic              clk,
  input  logic              reset,
  fp_stage_sequencer_if.slave bus
);

  seq_state_t         state;
  seq_state_t         state_next;

  logic [STAGE_W-1:0] stage_r;
  logic [STAGE_W-1:0] stage_next;
  logic               busy_r;
  logic               busy_next;
  logic               done_r;
  logic               done_next;

  logic               cnt_load;
  logic [Q_W-1:0]     cnt_load_value;
  logic               cnt_enable;
  logic [Q_W-1:0]     q;
  logic               q_zero;
  logic [Q_W-1:0]     stage_idx;
  logic               abort_req;

`ifdef FP_SEQ_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // q counts down from NUM_STAGES-1, so the active stage is the distance already travelled.
  assign stage_idx = Q_W'(STG_ALIGN + NUM_STAGES - 1) - q;

  step_down_counter #(
    .W (Q_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .enable     (cnt_enable),
    .q          (q),
    .zero       (q_zero)
  );

  // Next state, counter control and next values of the registered strobes.
  always_comb begin
    state_next     = state;
    stage_next     = '0;
    done_next      = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_enable     = 1'b0;
    case (state)
      ST_IDLE: begin
        // busy_r is still high during the done-pulse cycle; a start there is dropped.
        if (bus.clk_en && bus.start && !busy_r) begin
          state_next     = ST_RUN;
          cnt_load       = 1'b1;
          cnt_load_value = Q_W'(NUM_STAGES - 1);
        end
      end
      ST_RUN: begin
        if (abort_req) begin
          state_next = ST_IDLE;
          cnt_load   = 1'b1;
        end else if (bus.clk_en) begin
          stage_next = stage_strobe(stage_idx);
          if (q_zero) begin
            state_next = ST_DONE;
          end else begin
            cnt_enable = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        done_next  = !abort_req;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    // busy covers the whole operation including the cycle the done pulse is visible.
    busy_next = (state_next != ST_IDLE) || done_next;
  end

  // State and registered outputs; reset overrides every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      stage_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_next;
      stage_r <= stage_next;
      busy_r  <= busy_next;
      done_r  <= done_next;
    end
  end

  assign bus.stage = stage_r;
  assign bus.q     = q;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_fp_stage_sequencer.sv
// tb/tb_fp_stage_sequencer.sv - self-checking bench for fp_stage_sequencer with 4-stage and 2-stage instances
module tb_fp_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset    = 1'b1;
  logic start_in = 1'b0;
  logic clk_en_in = 1'b0;
  logic abort_in = 1'b0;

  int errors = 0;
  int checks = 0;

  fp_stage_sequencer_if bus4 ();
  fp_stage_sequencer_if bus2 ();

  assign bus4.start  = start_in;
  assign bus4.clk_en = clk_en_in;
  assign bus2.start  = start_in;
  assign bus2.clk_en = clk_en_in;
`ifdef FP_SEQ_ABORT_EN
  assign bus4.abort  = abort_in;
  assign bus2.abort  = abort_in;
`endif

  fp_stage_sequencer #(.NUM_STAGES(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
  fp_stage_sequencer #(.NUM_STAGES(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  logic [3:0] a_stage [2];
  logic [1:0] a_q     [2];
  logic       a_busy  [2];
  logic       a_done  [2];
  assign a_stage[0] = bus4.stage;
  assign a_stage[1] = bus2.stage;
  assign a_q[0]     = bus4.q;
  assign a_q[1]     = bus2.q;
  assign a_busy[0]  = bus4.busy;
  assign a_busy[1]  = bus2.busy;
  assign a_done[0]  = bus4.done;
  assign a_done[1]  = bus2.done;

  // Reference: an operation is "strobes issued so far" (-1 = none in flight) plus
  // a count of cycles spent after the last strobe (1 = done pulse visible).
  int         mk    [2] = '{-1, -1};
  int         mpost [2] = '{0, 0};
  logic [3:0] mstage[2] = '{4'h0, 4'h0};
  logic       mdone [2] = '{1'b0, 1'b0};

  function automatic int nstg(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic logic exp_busy(input int d);
    return mk[d] >= 0;
  endfunction

  function automatic logic [1:0] exp_q(input int d);
    if (mk[d] >= 0 && mk[d] < nstg(d)) return 2'(nstg(d) - 1 - mk[d]);
    return 2'd0;
  endfunction

  task automatic step(input logic s, input logic e, input logic r, input logic a);
    logic ab;
    ab = a;
`ifndef FP_SEQ_ABORT_EN
    ab = 1'b0;
`endif
    start_in  = s;
    clk_en_in = e;
    reset     = r;
    abort_in  = ab;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      mstage[d] = 4'h0;
      mdone[d]  = 1'b0;
      if (r) begin
        mk[d] = -1;
        mpost[d] = 0;
      end else if (mk[d] < 0) begin
        if (s && e) begin
          mk[d] = 0;
          mpost[d] = 0;
        end
      end else if (ab) begin
        mk[d] = -1;
      end else if (mk[d] < nstg(d)) begin
        if (e) begin
          mstage[d] = 4'(1 << mk[d]);
          mk[d]++;
        end
      end else begin
        mpost[d]++;
        if (mpost[d] == 1) mdone[d] = 1'b1;
        else mk[d] = -1;
      end
    end
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      for (int d = 0; d < 2; d++) begin
        checks += 4;
        if (a_stage[d] !== 4'h0) begin errors++; $display("FAIL reset_stage n=%0d: got %b expected 0000", nstg(d), a_stage[d]); end
        if (a_q[d] !== 2'd0) begin errors++; $display("FAIL reset_q n=%0d: got %0d expected 0", nstg(d), a_q[d]); end
        if (a_busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy n=%0d: got %b expected 0", nstg(d), a_busy[d]); end
        if (a_done[d] !== 1'b0) begin errors++; $display("FAIL reset_done n=%0d: got %b expected 0", nstg(d), a_done[d]); end
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_full_sequence();
    logic [3:0] exp_st [7] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
    logic       exp_dn [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_bz [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      checks += 3;
      if (a_stage[0] !== exp_st[i]) begin errors++; $display("FAIL full_stage cyc=%0d: got %b expected %b", i, a_stage[0], exp_st[i]); end
      if (a_done[0] !== exp_dn[i]) begin errors++; $display("FAIL full_done cyc=%0d: got %b expected %b", i, a_done[0], exp_dn[i]); end
      if (a_busy[0] !== exp_bz[i]) begin errors++; $display("FAIL full_busy cyc=%0d: got %b expected %b", i, a_busy[0], exp_bz[i]); end
      for (int d = 0; d < 2; d++) begin
        checks += 4;
        if (a_stage[d] !== mstage[d]) begin errors++; $display("FAIL full_model_stage n=%0d cyc=%0d: got %b expected %b", nstg(d), i, a_stage[d], mstage[d]); end
        if (a_done[d] !== mdone[d]) begin errors++; $display("FAIL full_model_done n=%0d cyc=%0d: got %b expected %b", nstg(d), i, a_done[d], mdone[d]); end
        if (a_busy[d] !== exp_busy(d)) begin errors++; $display("FAIL full_model_busy n=%0d cyc=%0d: got %b expected %b", nstg(d), i, a_busy[d], exp_busy(d)); end
        if (a_q[d] !== exp_q(d)) begin errors++; $display("FAIL full_model_q n=%0d cyc=%0d: got %0d expected %0d", nstg(d), i, a_q[d], exp_q(d)); end
      end
    end
    settle();
  endtask

  task automatic test_clk_en_toggle();
    logic [1:0] exp_qv [8] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [3:0] exp_st [8] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};
    settle();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (a_busy[0] !== 1'b0) begin errors++; $display("FAIL start_without_en busy: got %b expected 0", a_busy[0]); end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (a_q[0] !== 2'd3) begin errors++; $display("FAIL toggle_load_q: got %0d expected 3", a_q[0]); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, (i % 2) == 0, 1'b0, 1'b0);
      checks += 3;
      if (a_q[0] !== exp_qv[i]) begin errors++; $display("FAIL toggle_q cyc=%0d: got %0d expected %0d", i, a_q[0], exp_qv[i]); end
      if (a_stage[0] !== exp_st[i]) begin errors++; $display("FAIL toggle_stage cyc=%0d: got %b expected %b", i, a_stage[0], exp_st[i]); end
      if (a_done[0] !== (i == 7)) begin errors++; $display("FAIL toggle_done cyc=%0d: got %b expected %b", i, a_done[0], i == 7); end
      for (int d = 0; d < 2; d++) begin
        checks += 3;
        if (a_stage[d] !== mstage[d]) begin errors++; $display("FAIL toggle_model_stage n=%0d cyc=%0d: got %b expected %b", nstg(d), i, a_stage[d], mstage[d]); end
        if (a_done[d] !== mdone[d]) begin errors++; $display("FAIL toggle_model_done n=%0d cyc=%0d: got %b expected %b", nstg(d), i, a_done[d], mdone[d]); end
        if (a_q[d] !== exp_q(d)) begin errors++; $display("FAIL toggle_model_q n=%0d cyc=%0d: got %0d expected %0d", nstg(d), i, a_q[d], exp_q(d)); end
      end
    end
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    settle();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (a_q[0] !== 2'd1) begin errors++; $display("FAIL ignore_setup_q: got %0d expected 1", a_q[0]); end
    for (int i = 0; i < 7; i++) begin
      step(i < 4, 1'b1, 1'b0, 1'b0);
      if (a_done[0] === 1'b1) dones++;
      for (int d = 0; d < 2; d++) begin
        checks += 3;
        if (a_busy[d] !== exp_busy(d)) begin errors++; $display("FAIL ignore_model_busy n=%0d cyc=%0d: got %b expected %b", nstg(d), i, a_busy[d], exp_busy(d)); end
        if (a_done[d] !== mdone[d]) begin errors++; $display("FAIL ignore_model_done n=%0d cyc=%0d: got %b expected %b", nstg(d), i, a_done[d], mdone[d]); end
        if (a_q[d] !== exp_q(d)) begin errors++; $display("FAIL ignore_model_q n=%0d cyc=%0d: got %0d expected %0d", nstg(d), i, a_q[d], exp_q(d)); end
      end
    end
    checks += 2;
    if (dones != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
    if (a_busy[0] !== 1'b0) begin errors++; $display("FAIL ignore_no_restart busy: got %b expected 0", a_busy[0]); end
  endtask

  task automatic test_reset_mid_run();
    int dones = 0;
    settle();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (a_q[0] !== 2'd2) begin errors++; $display("FAIL midreset_setup_q: got %0d expected 2", a_q[0]); end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    checks += 4;
    if (a_q[0] !== 2'd0) begin errors++; $display("FAIL midreset_q: got %0d expected 0", a_q[0]); end
    if (a_busy[0] !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", a_busy[0]); end
    if (a_stage[0] !== 4'h0) begin errors++; $display("FAIL midreset_stage: got %b expected 0000", a_stage[0]); end
    if (a_done[0] !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", a_done[0]); end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (a_done[0] === 1'b1 || a_done[1] === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses expected 0", dones); end
  endtask

`ifdef FP_SEQ_ABORT_EN
  task automatic test_abort();
    int dones = 0;
    settle();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    checks += 4;
    if (a_q[0] !== 2'd0) begin errors++; $display("FAIL abort_q: got %0d expected 0", a_q[0]); end
    if (a_busy[0] !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", a_busy[0]); end
    if (a_stage[0] !== 4'h0) begin errors++; $display("FAIL abort_stage: got %b expected 0000", a_stage[0]); end
    if (a_done[0] !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", a_done[0]); end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (a_done[0] === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
      for (int d = 0; d < 2; d++) begin
        checks += 4;
        if (a_stage[d] !== mstage[d]) begin errors++; $display("FAIL rand_stage n=%0d cyc=%0d: got %b expected %b", nstg(d), i, a_stage[d], mstage[d]); end
        if (a_done[d] !== mdone[d]) begin errors++; $display("FAIL rand_done n=%0d cyc=%0d: got %b expected %b", nstg(d), i, a_done[d], mdone[d]); end
        if (a_busy[d] !== exp_busy(d)) begin errors++; $display("FAIL rand_busy n=%0d cyc=%0d: got %b expected %b", nstg(d), i, a_busy[d], exp_busy(d)); end
        if (a_q[d] !== exp_q(d)) begin errors++; $display("FAIL rand_q n=%0d cyc=%0d: got %0d expected %0d", nstg(d), i, a_q[d], exp_q(d)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_clk_en_toggle();
    test_start_ignored();
    test_reset_mid_run();
`ifdef FP_SEQ_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_stage_sequencer.md
FP_STAGE_SEQUENCER -- requirements
Module: fp_stage_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4, number of adder stages sequenced (legal 2..4).
REQ-002 clk  input  1  single system clock; all state SHALL change on posedge clk only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 clk_en  input  1  step enable; state advances only when high.
REQ-005 start  input  1  request to begin one operation, sampled when clk_en=1.
REQ-006 stage  output  4  one-hot stage strobe: bit0 align, bit1 add, bit2 normalize, bit3 pack.
REQ-007 q  output  2  remaining-step count, counts down.
REQ-008 busy  output  1  high while a sequence is in progress.
REQ-009 done  output  1  single-cycle completion pulse.

Function
REQ-010 The FSM SHALL have states IDLE, RUN, DONE; encoding is free.
REQ-011 IDLE with clk_en=1 and start=1 SHALL load q=NUM_STAGES-1 and enter RUN next cycle.
REQ-012 In RUN with clk_en=1, stage SHALL assert bit (NUM_STAGES-1-q) for exactly that cycle.
REQ-013 In RUN with clk_en=1 and q>0, q SHALL decrement by 1.
REQ-014 In RUN with clk_en=1 and q=0, the FSM SHALL enter DONE; q SHALL stay 0.
REQ-015 DONE SHALL assert done=1 for one cycle, then return to IDLE unconditionally, independent of clk_en.
REQ-016 With clk_en=0 in RUN, state and q SHALL hold and stage SHALL be 0.
REQ-017 stage, done, busy SHALL be registered outputs; stage timing follows REQ-012 with zero additional latency beyond the register.
REQ-018 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-019 start while busy=1 SHALL be ignored; no queuing.
REQ-020 start with clk_en=0 in IDLE SHALL be ignored.
REQ-021 At most one stage bit SHALL ever be high; stage=0 outside RUN.
REQ-022 Total latency start-accept to done SHALL be NUM_STAGES enabled cycles plus one cycle.
REQ-023 q SHALL never wrap below 0.

Reset
REQ-024 reset=1 SHALL force IDLE, q=0, stage=0, busy=0, done=0 at the next posedge, overriding all inputs.
REQ-025 reset asserted mid-RUN SHALL abandon the sequence with no done pulse.

Configuration
REQ-026 Macro FP_SEQ_ABORT_EN, when defined, SHALL add input abort (1 bit); abort=1 in RUN or DONE SHALL return to IDLE next cycle with q=0, stage=0, done=0.
REQ-027 abort SHALL take priority over clk_en and start but not over reset.
REQ-028 Without FP_SEQ_ABORT_EN, no abort port SHALL exist and behaviour is REQ-010..REQ-025 only.

Structure
REQ-029 Shared package fp_adder_pkg SHALL hold the FSM state typedef and stage index constants STG_ALIGN=0, STG_ADD=1, STG_NORM=2, STG_PACK=3.
REQ-030 The down-counter SHALL be a sub-module step_down_counter (load, enable, 2-bit q, zero flag).

Verification
REQ-031 Reset, then start=1, clk_en=1 held -> stage 0001,0010,0100,1000 on successive cycles, then done=1 one cycle, busy falls after.
REQ-032 Start accepted, clk_en toggles 1,0,1,0 -> stage pulses only on enabled cycles, q holds (3,2,2,1,1...), done after 4th enabled step.
REQ-033 start re-asserted at q=1 -> ignored; exactly one done pulse; no restart.
REQ-034 reset asserted at q=2 -> next cycle q=0, busy=0, stage=0, no done.
REQ-035 NUM_STAGES=2 -> stage 0001,0010 then done; bits 2,3 never assert.
REQ-036 With FP_SEQ_ABORT_EN, abort at q=1 with clk_en=1 -> IDLE next cycle, no done, stage=0.
